// File: rtl/hd_encoder_ctrl.sv
// rtl/hd_encoder_ctrl.sv - control sequencer building and bundling n-gram hypervectors for the HD encoder
module hd_encoder_ctrl #(
  parameter int NGRAM_MAX        = 8,
  parameter int SAMPLE_CNT_WIDTH = 10,
  parameter int MAN_VALUE_WIDTH  = 8,
  parameter int CTX_IDX_WIDTH    = 2,
  localparam int NGW             = $clog2(NGRAM_MAX + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic                        abort_i,
  input  logic [NGW-1:0]              cfg_ngram_i,
  input  logic [SAMPLE_CNT_WIDTH-1:0] cfg_num_samples_i,
  input  logic [CTX_IDX_WIDTH-1:0]    cfg_ctx_idx_i,
  input  logic                        cfg_accumulate_i,
  output logic                        busy_o,
  output logic                        done_o,
  input  logic                        sample_valid_i,
  output logic                        sample_ready_o,
  input  logic [MAN_VALUE_WIDTH-1:0]  sample_value_i,
  output logic                        mem_rd_o,
  output logic [MAN_VALUE_WIDTH-1:0]  ext_man_value_o,
  output logic                        man_en_o,
  output logic [1:0]                  man_input_sel_o,
  output logic                        man_value_sel_o,
  output logic                        mixer_en_o,
  output logic                        mixer_inverse_o,
  output logic                        mixer_perm_sel_o,
  output logic [1:0]                  hd_op_sel_o,
  output logic                        en_bundle_cntr_o,
  output logic                        rst_bundle_cntr_o,
  output logic [CTX_IDX_WIDTH-1:0]    bundle_ctx_idx_o,
  output logic                        bundle_ctx_we_o,
  output logic                        bundle_ctx_add_o
);

  // Datapath operand / mux encodings
  localparam logic [1:0] OP_NOP         = 2'd0;
  localparam logic [1:0] OP_PASS        = 2'd1;
  localparam logic [1:0] OP_XOR         = 2'd2;
  localparam logic [1:0] SEL_ZERO       = 2'd0;
  localparam logic [1:0] SEL_MEMORY     = 2'd1;
  localparam logic [1:0] SEL_OUTPUT_REG = 2'd2;
  localparam logic       VAL_INTERNAL   = 1'b0;
  localparam logic       VAL_EXTERNAL   = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_FETCH, S_LOAD, S_BIND, S_PERM, S_BUNDLE, S_STORE
  } state_e;

  state_e                      state_q, state_d;
  logic [NGW-1:0]              n_q, n_norm, j_q, j_inc;
  logic [SAMPLE_CNT_WIDTH-1:0] ns_q, s_q, s_inc;
  logic [CTX_IDX_WIDTH-1:0]    ctx_q;
  logic                        acc_q;

  // Item-memory read is the only Mealy output: it follows the handshake directly
  assign mem_rd_o = (state_q == S_FETCH) && sample_valid_i;

  assign j_inc = j_q + NGW'(1);
  assign s_inc = s_q + SAMPLE_CNT_WIDTH'(1);

  // N=0 behaves as unigrams, oversized N clamps to the largest supported n-gram
  assign n_norm = (cfg_ngram_i == '0) ? NGW'(1) :
                  (cfg_ngram_i > NGW'(NGRAM_MAX)) ? NGW'(NGRAM_MAX) : cfg_ngram_i;

  // Next-state selection; abort overrides every non-idle transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_i && (cfg_num_samples_i != '0)) state_d = S_CLR;
      S_CLR:    state_d = S_FETCH;
      S_FETCH:  if (sample_valid_i) state_d = (j_q == '0) ? S_LOAD : S_BIND;
      S_LOAD,
      S_BIND:   state_d = ((j_inc == n_q) || (s_inc == ns_q)) ? S_BUNDLE : S_PERM;
      S_PERM:   state_d = S_FETCH;
      S_BUNDLE: state_d = (s_q < ns_q) ? S_FETCH : S_STORE;
      S_STORE:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (abort_i && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  // State, counters, latched config and outputs registered from the upcoming state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q           <= S_IDLE;
      n_q               <= '0;
      ns_q              <= '0;
      ctx_q             <= '0;
      acc_q             <= 1'b0;
      s_q               <= '0;
      j_q               <= '0;
      ext_man_value_o   <= '0;
      done_o            <= 1'b0;
      busy_o            <= 1'b0;
      sample_ready_o    <= 1'b0;
      man_en_o          <= 1'b0;
      man_input_sel_o   <= SEL_ZERO;
      man_value_sel_o   <= VAL_INTERNAL;
      mixer_en_o        <= 1'b0;
      mixer_inverse_o   <= 1'b0;
      mixer_perm_sel_o  <= 1'b0;
      hd_op_sel_o       <= OP_NOP;
      en_bundle_cntr_o  <= 1'b0;
      rst_bundle_cntr_o <= 1'b0;
      bundle_ctx_idx_o  <= '0;
      bundle_ctx_we_o   <= 1'b0;
      bundle_ctx_add_o  <= 1'b0;
    end else begin
      state_q <= state_d;

      if ((state_q == S_IDLE) && start_i) begin
        n_q   <= n_norm;
        ns_q  <= cfg_num_samples_i;
        ctx_q <= cfg_ctx_idx_i;
        acc_q <= cfg_accumulate_i;
      end

      case (state_q)
        S_CLR: begin
          s_q <= '0;
          j_q <= '0;
        end
        S_LOAD, S_BIND: begin
          s_q <= s_inc;
          j_q <= j_inc;
        end
        S_BUNDLE: j_q <= '0;
        default: ;
      endcase

      if (mem_rd_o) ext_man_value_o <= sample_value_i;

      done_o <= ((state_q == S_IDLE) && start_i && (cfg_num_samples_i == '0)) ||
                ((state_q == S_STORE) && !abort_i);

      busy_o            <= (state_d != S_IDLE);
      sample_ready_o    <= 1'b0;
      man_en_o          <= 1'b0;
      man_input_sel_o   <= SEL_ZERO;
      man_value_sel_o   <= VAL_INTERNAL;
      mixer_en_o        <= 1'b0;
      mixer_inverse_o   <= 1'b0;
      mixer_perm_sel_o  <= 1'b0;
      hd_op_sel_o       <= OP_NOP;
      en_bundle_cntr_o  <= 1'b0;
      rst_bundle_cntr_o <= 1'b0;
      bundle_ctx_idx_o  <= '0;
      bundle_ctx_we_o   <= 1'b0;
      bundle_ctx_add_o  <= 1'b0;

      case (state_d)
        S_CLR:   rst_bundle_cntr_o <= 1'b1;
        S_FETCH: sample_ready_o    <= 1'b1;
        S_LOAD, S_BIND: begin
          man_input_sel_o <= SEL_MEMORY;
          man_en_o        <= 1'b1;
          man_value_sel_o <= VAL_EXTERNAL;
          hd_op_sel_o     <= (state_d == S_BIND) ? OP_XOR : OP_PASS;
        end
        S_PERM: begin
          man_input_sel_o <= SEL_OUTPUT_REG;
          mixer_en_o      <= 1'b1;
          hd_op_sel_o     <= OP_PASS;
        end
        S_BUNDLE: en_bundle_cntr_o <= 1'b1;
        S_STORE: begin
          bundle_ctx_we_o  <= 1'b1;
          bundle_ctx_idx_o <= ctx_q;
          bundle_ctx_add_o <= acc_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hd_encoder_ctrl.sv
// tb/tb_hd_encoder_ctrl.sv - directed self-checking bench for hd_encoder_ctrl
module tb_hd_encoder_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       start_i = 1'b0;
  logic       abort_i = 1'b0;
  logic [3:0] cfg_ngram_i = '0;
  logic [9:0] cfg_num_samples_i = '0;
  logic [1:0] cfg_ctx_idx_i = '0;
  logic       cfg_accumulate_i = 1'b0;
  logic       busy_o, done_o;
  logic       sample_valid_i = 1'b0;
  logic       sample_ready_o;
  logic [7:0] sample_value_i = '0;
  logic       mem_rd_o;
  logic [7:0] ext_man_value_o;
  logic       man_en_o;
  logic [1:0] man_input_sel_o;
  logic       man_value_sel_o;
  logic       mixer_en_o, mixer_inverse_o, mixer_perm_sel_o;
  logic [1:0] hd_op_sel_o;
  logic       en_bundle_cntr_o, rst_bundle_cntr_o;
  logic [1:0] bundle_ctx_idx_o;
  logic       bundle_ctx_we_o, bundle_ctx_add_o;

  int n_cmp  = 0;
  int n_fail = 0;

  hd_encoder_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .cfg_ngram_i(cfg_ngram_i), .cfg_num_samples_i(cfg_num_samples_i),
    .cfg_ctx_idx_i(cfg_ctx_idx_i), .cfg_accumulate_i(cfg_accumulate_i),
    .busy_o(busy_o), .done_o(done_o),
    .sample_valid_i(sample_valid_i), .sample_ready_o(sample_ready_o),
    .sample_value_i(sample_value_i), .mem_rd_o(mem_rd_o),
    .ext_man_value_o(ext_man_value_o), .man_en_o(man_en_o),
    .man_input_sel_o(man_input_sel_o), .man_value_sel_o(man_value_sel_o),
    .mixer_en_o(mixer_en_o), .mixer_inverse_o(mixer_inverse_o),
    .mixer_perm_sel_o(mixer_perm_sel_o), .hd_op_sel_o(hd_op_sel_o),
    .en_bundle_cntr_o(en_bundle_cntr_o), .rst_bundle_cntr_o(rst_bundle_cntr_o),
    .bundle_ctx_idx_o(bundle_ctx_idx_o), .bundle_ctx_we_o(bundle_ctx_we_o),
    .bundle_ctx_add_o(bundle_ctx_add_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Map the registered control outputs back to a state letter
  function automatic byte classify();
    if (!busy_o)                                 return "I";
    if (rst_bundle_cntr_o)                       return "C";
    if (sample_ready_o)                          return "F";
    if (man_en_o && (hd_op_sel_o == 2'd2))       return "X";
    if (man_en_o && (hd_op_sel_o == 2'd1))       return "L";
    if (mixer_en_o)                              return "P";
    if (en_bundle_cntr_o)                        return "B";
    if (bundle_ctx_we_o)                         return "S";
    return "?";
  endfunction

  task automatic run_job(input logic [3:0] n, input logic [9:0] ns, input logic [1:0] ctx,
                         input logic acc, input string exp, input int nbun,
                         input logic [15:0] stall_pat, input int abort_at);
    int  k = 0, cyc = 0, bun = 0, cnt_we = 0, exp_we = 0;
    bit  fin = 0, aborted = 0, done_seen = 0, we_seen = 0;
    byte c;
    logic [7:0] held = '0;
    for (int i = 0; i < exp.len(); i++) if (exp[i] == "S") exp_we++;
    @(negedge clk_i);
    start_i = 1'b1; cfg_ngram_i = n; cfg_num_samples_i = ns;
    cfg_ctx_idx_i = ctx; cfg_accumulate_i = acc; sample_valid_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; cfg_ngram_i = 4'd1; cfg_num_samples_i = 10'd1;
    cfg_ctx_idx_i = ~ctx; cfg_accumulate_i = ~acc;
    while (!fin && cyc < 200) begin
      sample_valid_i = ~stall_pat[cyc % 16];
      sample_value_i = 8'(8'h40 + cyc * 3);
      #1;
      c = classify();
      if (bundle_ctx_we_o) cnt_we++;
      if (k == exp.len()) begin
        check("done", done_o, 1'b1);
        check("busy_end", busy_o, 1'b0);
        check("bundle_cnt", bun, nbun);
        check("store_cnt", cnt_we, exp_we);
        fin = 1;
      end else begin
        check("state", c, exp[k]);
        check("mem_rd", mem_rd_o, (c == "F") && sample_valid_i);
        check("busy", busy_o, 1'b1);
        check("no_early_done", done_o, 1'b0);
        if (c == "F") begin
          if (sample_valid_i) begin
            held = sample_value_i;
            k++;
          end
        end else begin
          if (c == "L" || c == "X") begin
            check("ext_value", ext_man_value_o, held);
            check("man_ctrl", {man_input_sel_o, man_value_sel_o, mixer_en_o}, {2'd1, 1'b1, 1'b0});
          end
          if (c == "P")
            check("perm_ctrl", {man_en_o, man_input_sel_o, hd_op_sel_o, mixer_inverse_o, mixer_perm_sel_o},
                  {1'b0, 2'd2, 2'd1, 1'b0, 1'b0});
          if (c == "B") bun++;
          if (c == "S") begin
            check("store_idx", bundle_ctx_idx_o, ctx);
            check("store_add", bundle_ctx_add_o, acc);
          end
          k++;
        end
        if (abort_at >= 0 && k == abort_at + 1) begin
          abort_i = 1'b1;
          fin = 1;
          aborted = 1;
        end
      end
      cyc++;
      if (!fin) @(negedge clk_i);
    end
    check("job_timeout", fin, 1'b1);
    if (aborted) begin
      @(negedge clk_i);
      abort_i = 1'b0;
      #1;
      check("abort_busy", busy_o, 1'b0);
      check("abort_ready", sample_ready_o, 1'b0);
      check("abort_idle", classify(), "I");
      repeat (25) begin
        @(negedge clk_i);
        if (done_o) done_seen = 1;
        if (bundle_ctx_we_o) we_seen = 1;
      end
      check("abort_no_done", done_seen, 1'b0);
      check("abort_no_store", we_seen, 1'b0);
    end else begin
      @(negedge clk_i);
      #1;
      check("done_pulse", done_o, 1'b0);
      check("idle_no_clr", rst_bundle_cntr_o, 1'b0);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk_i);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_ready", sample_ready_o, 1'b0);
    check("rst_ext", ext_man_value_o, 8'h00);
    check("rst_ctrl", {man_en_o, man_input_sel_o, man_value_sel_o, mixer_en_o, hd_op_sel_o,
                       en_bundle_cntr_o, rst_bundle_cntr_o, bundle_ctx_we_o}, 32'h0);
    rst_ni = 1'b1;

    // N=3, 6 samples: two full groups, done lands on cycle 21
    run_job(4'd3, 10'd6, 2'd2, 1'b1, "CFLPFXPFXBFLPFXPFXBS", 2, 16'h0000, -1);
    // N=1: unigrams, no PERM/BIND
    run_job(4'd1, 10'd4, 2'd1, 1'b0, "CFLBFLBFLBFLBS", 4, 16'h0000, -1);
    // N=4, 5 samples: partial trailing group
    run_job(4'd4, 10'd5, 2'd3, 1'b0, "CFLPFXPFXPFXBFLBS", 2, 16'h0000, -1);
    // N=2 with valid stalls
    run_job(4'd2, 10'd4, 2'd0, 1'b1, "CFLPFXBFLPFXBS", 2, 16'b0110_0100_1001_0110, -1);
    // N=0 behaves as N=1
    run_job(4'd0, 10'd2, 2'd1, 1'b1, "CFLBFLBS", 2, 16'h0000, -1);
    // N=12 saturates to 8
    run_job(4'd12, 10'd9, 2'd2, 1'b0, "CFLPFXPFXPFXPFXPFXPFXPFXBFLBS", 2, 16'h0000, -1);
    // Abort during the second PERM
    run_job(4'd3, 10'd6, 2'd2, 1'b1, "CFLPFXPFXBFLPFXPFXBS", 0, 16'h0000, 6);
    // Empty job: immediate done without clear or store
    run_job(4'd3, 10'd0, 2'd1, 1'b1, "", 0, 16'h0000, -1);

    // Asynchronous reset mid-job
    @(negedge clk_i);
    start_i = 1'b1; cfg_ngram_i = 4'd2; cfg_num_samples_i = 10'd4; sample_valid_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("midjob_busy", busy_o, 1'b1);
    #1 rst_ni = 1'b0;
    #1;
    check("async_rst_busy", busy_o, 1'b0);
    check("async_rst_ready", sample_ready_o, 1'b0);
    check("async_rst_ext", ext_man_value_o, 8'h00);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("post_rst_idle", busy_o, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
